// File: rtl/multicycle_control_fsm.sv
// ============================================================================
//  Module   : multicycle_control_fsm
//  Purpose  : Main control sequencer for the multicycle RV32I core.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
    parameter int OP_WIDTH     = 7,
    parameter int ALU_OP_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OP_WIDTH-1:0]     op,
    input  logic                    zero,
    output logic                    PCWrite,
    output logic                    AdrSrc,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic                    RegWrite,
    output logic [1:0]              ResultSrc,
    output logic [1:0]              ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [ALU_OP_WIDTH-1:0] ALUOp,
    output logic                    retire,
    output logic                    illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [OP_WIDTH-1:0] c_OP_LOAD  = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] c_OP_STORE = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] c_OP_RTYPE = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] c_OP_ITYPE = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] c_OP_JAL   = OP_WIDTH'(7'b1101111);
    localparam logic [OP_WIDTH-1:0] c_OP_BEQ   = OP_WIDTH'(7'b1100011);

    state_t r_state;
    logic   r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:   r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        c_OP_LOAD, c_OP_STORE: r_state <= S_MEMADR;
                        c_OP_RTYPE:            r_state <= S_EXECR;
                        c_OP_ITYPE:            r_state <= S_EXECI;
                        c_OP_JAL:              r_state <= S_JAL;
                        c_OP_BEQ:              r_state <= S_BEQ;
                        default: begin
                            r_state   <= S_TRAP;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:  r_state <= (op == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: r_state <= S_MEMWB;
                S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: r_state <= S_FETCH;
                S_EXECR, S_EXECI, S_JAL:             r_state <= S_ALUWB;
                S_TRAP:    r_state <= S_TRAP;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    logic                    w_pc_update;
    logic                    w_branch;
    logic                    w_adr_src;
    logic                    w_mem_write;
    logic                    w_ir_write;
    logic                    w_reg_write;
    logic [1:0]              w_result_src;
    logic [1:0]              w_alu_src_a;
    logic [1:0]              w_alu_src_b;
    logic [ALU_OP_WIDTH-1:0] w_alu_op;
    logic                    w_retire;

    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = '0;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_update  = 1'b1;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            S_MEMREAD: w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = ALU_OP_WIDTH'(2'b10);
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = ALU_OP_WIDTH'(2'b10);
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = ALU_OP_WIDTH'(2'b01);
                w_branch    = 1'b1;
                w_retire    = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset holds the state at FETCH, so only the enables need gating here.
    assign PCWrite   = rst_n & (w_pc_update | (w_branch & zero));
    assign AdrSrc    = w_adr_src;
    assign MemWrite  = rst_n & w_mem_write;
    assign IRWrite   = rst_n & w_ir_write;
    assign RegWrite  = rst_n & w_reg_write;
    assign ResultSrc = w_result_src;
    assign ALUSrcA   = w_alu_src_a;
    assign ALUSrcB   = w_alu_src_b;
    assign ALUOp     = w_alu_op;
    assign retire    = rst_n & w_retire;
    assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
//  Module   : tb_multicycle_control_fsm
//  Purpose  : Self-checking bench for multicycle_control_fsm.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op    = 7'd0;
    logic       zero  = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;

    multicycle_control_fsm #(.OP_WIDTH(7), .ALU_OP_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef logic [14:0] vec_t;
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MW = 4, P_MWR = 5;
    localparam int P_ER = 6, P_EI = 7, P_AW = 8, P_J = 9, P_B = 10, P_T = 11;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b0110111;

    int   total = 0, bad = 0;
    int   cyc = 0;
    vec_t exp_q[$];
    int   ph_q[$];
    int   ret_cyc[$];
    vec_t w_act;

    assign w_act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp, retire, illegal};

    // Output bundle each instruction phase must present.
    function automatic vec_t phase_vec(int ph, bit z);
        logic pcw, adr, memw, irw, regw, ret, ill;
        logic [1:0] rs, a, b, aop;
        {pcw, adr, memw, irw, regw, ret, ill} = '0;
        {rs, a, b, aop} = '0;
        case (ph)
            P_F:   begin pcw = 1; irw = 1; rs = 2; b = 2; end
            P_D:   begin a = 1; b = 1; end
            P_MA:  begin a = 2; b = 1; end
            P_MR:  adr = 1;
            P_MW:  begin rs = 1; regw = 1; ret = 1; end
            P_MWR: begin adr = 1; memw = 1; ret = 1; end
            P_ER:  begin a = 2; aop = 2; end
            P_EI:  begin a = 2; b = 1; aop = 2; end
            P_AW:  begin regw = 1; ret = 1; end
            P_J:   begin pcw = 1; a = 1; b = 2; end
            P_B:   begin a = 2; aop = 1; pcw = z; ret = 1; end
            P_T:   ill = 1;
            default: ;
        endcase
        return {pcw, adr, memw, irw, regw, rs, a, b, aop, ret, ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int ph, input bit z);
        exp_q.push_back(phase_vec(ph, z));
        ph_q.push_back(ph);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Queues the expected per-cycle outputs of one instruction; returns its length.
    task automatic queue_instr(input logic [6:0] o, input bit z, output int n);
        push(P_F, z);
        push(P_D, z);
        case (o)
            LW:      begin push(P_MA, z); push(P_MR, z); push(P_MW, z); n = 5; end
            SW:      begin push(P_MA, z); push(P_MWR, z); n = 4; end
            RT:      begin push(P_ER, z); push(P_AW, z); n = 4; end
            IT:      begin push(P_EI, z); push(P_AW, z); n = 4; end
            JL:      begin push(P_J, z);  push(P_AW, z); n = 4; end
            BQ:      begin push(P_B, z); n = 3; end
            default: begin for (int i = 0; i < 20; i++) push(P_T, z); n = 22; end
        endcase
    endtask

    task automatic run_instr(input logic [6:0] o, input bit z);
        int n;
        op   = o;
        zero = z;
        queue_instr(o, z, n);
        cycles(n);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        vec_t e;
        int   p;
        if (retire === 1'b1) ret_cyc.push_back(cyc);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = ph_q.pop_front();
            chk($sformatf("phase%0d_outputs", p), 32'(w_act), 32'(e));
        end
    end

    localparam vec_t c_RESET_VEC = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};

    initial begin
        int n;
        #3;
        chk("reset_outputs", 32'(w_act), 32'(c_RESET_VEC));
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_held_outputs", 32'(w_act), 32'(c_RESET_VEC));
        #1;
        rst_n = 1'b1;
        #1;
        chk("release_irwrite", 32'(IRWrite), 32'd1);

        run_instr(LW, 1'b0);
        chk("lw_retire_count", 32'(ret_cyc.size()), 32'd1);

        run_instr(SW, 1'b1);
        run_instr(RT, 1'b0);
        chk("sw_r_retire_gap", 32'(ret_cyc[$] - ret_cyc[$-1]), 32'd4);
        run_instr(IT, 1'b1);
        run_instr(JL, 1'b0);
        run_instr(BQ, 1'b1);
        run_instr(BQ, 1'b0);
        chk("beq_retire_gap", 32'(ret_cyc[$] - ret_cyc[$-1]), 32'd3);

        // op and zero scrambled once MEMADR has sampled op: no effect expected
        op = LW; zero = 1'b0;
        queue_instr(LW, 1'b0, n);
        cycles(3);
        op = BAD; zero = 1'b1;
        cycles(2);

        // Reset during MEMREAD of a lw abandons it
        op = LW; zero = 1'b0;
        push(P_F, 1'b0); push(P_D, 1'b0); push(P_MA, 1'b0); push(P_MR, 1'b0);
        cycles(3);
        #4;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 32'(w_act), 32'(c_RESET_VEC));
        @(posedge clk);
        #1;
        chk("midreset_no_regwrite", 32'(RegWrite), 32'd0);
        #1;
        rst_n = 1'b1;
        run_instr(RT, 1'b0);

        run_instr(BAD, 1'b1);
        chk("trap_illegal_held", 32'(illegal), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("trap_async_clear", 32'(illegal), 32'd0);
        chk("trap_reset_fetch_sel", 32'(ALUSrcB), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_instr(BQ, 1'b1);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("total_retires", 32'(ret_cyc.size()), 32'd10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
